// File: rtl/cue_pkg.sv
// Shared definitions for the cue aiming slice: FSM states, vector widths
// and the cosine lookup used by the direction ROM.
package cue_pkg;

  localparam int ANGLE_BITS     = 6;
  localparam int TRIG_FRAC_BITS = 7;
  localparam int VEL_W          = 11;

  typedef enum logic [1:0] {
    WAIT_STOP = 2'd0,
    AIM       = 2'd1,
    FIRE      = 2'd2
  } aim_state_t;

  // First quadrant (plus the 90 degree point) of round(127*cos(k*5.625 deg)).
  function automatic logic [6:0] quarter_cos(input logic [4:0] idx);
    logic [6:0] mag;
    case (idx)
      5'd0:    mag = 7'd127;
      5'd1:    mag = 7'd126;
      5'd2:    mag = 7'd125;
      5'd3:    mag = 7'd122;
      5'd4:    mag = 7'd117;
      5'd5:    mag = 7'd112;
      5'd6:    mag = 7'd106;
      5'd7:    mag = 7'd98;
      5'd8:    mag = 7'd90;
      5'd9:    mag = 7'd81;
      5'd10:   mag = 7'd71;
      5'd11:   mag = 7'd60;
      5'd12:   mag = 7'd49;
      5'd13:   mag = 7'd37;
      5'd14:   mag = 7'd25;
      5'd15:   mag = 7'd12;
      default: mag = 7'd0;
    endcase
    return mag;
  endfunction

  // Full-circle cosine folded onto the quarter table by quadrant symmetry.
  function automatic logic signed [7:0] cos_lookup(input logic [ANGLE_BITS-1:0] k);
    logic [ANGLE_BITS-1:0] idx;
    logic                  neg;
    logic signed [7:0]     mag;
    if (k <= 6'd16) begin
      idx = k;
      neg = 1'b0;
    end else if (k <= 6'd32) begin
      idx = 6'd32 - k;
      neg = 1'b1;
    end else if (k <= 6'd48) begin
      idx = k - 6'd32;
      neg = 1'b1;
    end else begin
      idx = 6'd0 - k;
      neg = 1'b0;
    end
    mag = $signed({1'b0, quarter_cos(idx[4:0])});
    return neg ? -mag : mag;
  endfunction

  // Sine is cosine a quarter turn (16 steps) earlier.
  function automatic logic signed [7:0] sin_lookup(input logic [ANGLE_BITS-1:0] k);
    return cos_lookup(k - 6'd16);
  endfunction

endpackage

// File: rtl/cue_direction_lut.sv
// Registered 64-entry cos/sin ROM in Q1.7; first stage of the aim vector pipeline.
module cue_direction_lut
  import cue_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ANGLE_BITS-1:0] angle,
  output logic signed [7:0]     cos,
  output logic signed [7:0]     sin
);

  // Look up both components and register them, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cos <= '0;
      sin <= '0;
    end else begin
      cos <= cos_lookup(angle);
      sin <= sin_lookup(angle);
    end
  end

endmodule

// File: rtl/cue_aim_controller.sv
// Cue ball aiming and shot-launch controller: keys -> angle/power ->
// signed velocity vector, with a one-cycle shot command.
// Optional feature macro: CUE_POWER_ADJUST_EN (up/down power keys);
// without it power stays fixed and the up/down keys are ignored.
module cue_aim_controller
  import cue_pkg::*;
#(
  parameter int POWER_MIN     = 16,
  parameter int POWER_MAX     = 200,
  parameter int POWER_DEFAULT = 100,
  parameter int REPEAT_FRAMES = 4,
  parameter int STOP_FRAMES   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    keyLeftIsPressed,
  input  logic                    keyRightIsPressed,
  input  logic                    keyUpIsPressed,
  input  logic                    keyDownIsPressed,
  input  logic                    keyEnterIsPressed,
  input  logic                    ballsStopped,
  output logic signed [VEL_W-1:0] velocityX,
  output logic signed [VEL_W-1:0] velocityY,
  output logic                    aimValid,
  output logic                    shotFire,
  output logic signed [VEL_W-1:0] shotVelocityX,
  output logic signed [VEL_W-1:0] shotVelocityY
);

  localparam int POWER_INIT = (POWER_DEFAULT < POWER_MIN) ? POWER_MIN :
                              (POWER_DEFAULT > POWER_MAX) ? POWER_MAX : POWER_DEFAULT;

  aim_state_t            state, next_state;
  logic [ANGLE_BITS-1:0] angle;
  logic [7:0]            power, power_d;
  logic [7:0]            left_count, right_count, stop_count;
  logic                  frame_in_aim, step_left, step_right;
  logic                  enter_prev, enter_edge;
  logic signed [7:0]     cos_val, sin_val;
  logic signed [16:0]    prod_x, prod_y;

  // Held keys step immediately, then once every REPEAT_FRAMES frames.
  function automatic logic [7:0] next_repeat(input logic pressed, input logic [7:0] count);
    if (!pressed || count == 8'(REPEAT_FRAMES - 1)) return 8'd0;
    return count + 8'd1;
  endfunction

  assign frame_in_aim = startOfFrame && (state == AIM);
  assign step_left    = keyLeftIsPressed  && (left_count  == 8'd0);
  assign step_right   = keyRightIsPressed && (right_count == 8'd0);

  // Angle stepping with wrap-around; repeat counters idle outside AIM.
  always_ff @(posedge clk) begin
    if (reset) begin
      angle       <= '0;
      left_count  <= '0;
      right_count <= '0;
    end else if (state != AIM) begin
      left_count  <= '0;
      right_count <= '0;
    end else if (startOfFrame) begin
      left_count  <= next_repeat(keyLeftIsPressed, left_count);
      right_count <= next_repeat(keyRightIsPressed, right_count);
      if (step_right && !step_left)
        angle <= angle + 6'd1;
      else if (step_left && !step_right)
        angle <= angle - 6'd1;
    end
  end

`ifdef CUE_POWER_ADJUST_EN
  logic [7:0] up_count, down_count;
  logic       step_up, step_down;

  assign step_up   = keyUpIsPressed   && (up_count   == 8'd0);
  assign step_down = keyDownIsPressed && (down_count == 8'd0);

  // Saturating power adjustment with the same repeat behaviour as the angle keys.
  always_ff @(posedge clk) begin
    if (reset) begin
      power      <= 8'(POWER_INIT);
      up_count   <= '0;
      down_count <= '0;
    end else if (state != AIM) begin
      up_count   <= '0;
      down_count <= '0;
    end else if (frame_in_aim) begin
      up_count   <= next_repeat(keyUpIsPressed, up_count);
      down_count <= next_repeat(keyDownIsPressed, down_count);
      if (step_up && !step_down && power < 8'(POWER_MAX))
        power <= power + 8'd1;
      else if (step_down && !step_up && power > 8'(POWER_MIN))
        power <= power - 8'd1;
    end
  end
`else
  logic unused_power_keys;

  // Power is fixed; the up/down keys have no effect in this build.
  assign power             = 8'(POWER_INIT);
  assign unused_power_keys = keyUpIsPressed ^ keyDownIsPressed ^ frame_in_aim;
`endif

  cue_direction_lut u_lut (
    .clk   (clk),
    .reset (reset),
    .angle (angle),
    .cos   (cos_val),
    .sin   (sin_val)
  );

  assign prod_x = cos_val * $signed({1'b0, power_d});
  assign prod_y = sin_val * $signed({1'b0, power_d});

  // Power is delayed alongside the LUT stage so angle and power changes both
  // reach the vector two cycles later; second stage scales and floors.
  always_ff @(posedge clk) begin
    if (reset) begin
      power_d   <= 8'(POWER_INIT);
      velocityX <= '0;
      velocityY <= '0;
    end else begin
      power_d   <= power;
      velocityX <= VEL_W'(prod_x >>> TRIG_FRAC_BITS);
      velocityY <= VEL_W'(prod_y >>> TRIG_FRAC_BITS);
    end
  end

  // Enter rising edge, only armed while aiming so a key held on entry never fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_prev <= 1'b0;
      enter_edge <= 1'b0;
    end else begin
      enter_prev <= keyEnterIsPressed;
      enter_edge <= keyEnterIsPressed && !enter_prev && (state == AIM);
    end
  end

  // Consecutive stopped-frame counter, active only while waiting.
  always_ff @(posedge clk) begin
    if (reset)
      stop_count <= '0;
    else if (state != WAIT_STOP || next_state != WAIT_STOP)
      stop_count <= '0;
    else if (startOfFrame)
      stop_count <= ballsStopped ? stop_count + 8'd1 : 8'd0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= WAIT_STOP;
    else
      state <= next_state;
  end

  // FSM next-state logic; losing the stopped status wins over a pending shot.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_STOP:
        if (startOfFrame && ballsStopped && stop_count == 8'(STOP_FRAMES - 1))
          next_state = AIM;
      AIM:
        if (!ballsStopped)
          next_state = WAIT_STOP;
        else if (enter_edge)
          next_state = FIRE;
      FIRE:
        next_state = WAIT_STOP;
      default:
        next_state = WAIT_STOP;
    endcase
  end

  // FSM outputs.
  always_comb begin
    aimValid = (state == AIM);
    shotFire = (state == FIRE);
  end

  // Capture the vector on entry to FIRE so it is valid during the pulse and held after.
  always_ff @(posedge clk) begin
    if (reset) begin
      shotVelocityX <= '0;
      shotVelocityY <= '0;
    end else if (next_state == FIRE) begin
      shotVelocityX <= velocityX;
      shotVelocityY <= velocityY;
    end
  end

endmodule
